// File: rtl/pwm_sinc2_demodulator.sv
// PWM-to-PCM receiver: measures the high time of each PWM period and
// decimates the resulting pulse widths through a sinc^2 (order-2 CIC) filter.
module pwm_sinc2_demodulator #(
  parameter int PWM_BITS       = 7,
  parameter int MAX_LOG2_DECIM = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pwm_in,
  input  logic                                  sync,
  input  logic [PWM_BITS-1:0]                   period_max,
  input  logic [2:0]                            log2_decim,
  input  logic                                  clear,
  output logic [PWM_BITS+2*MAX_LOG2_DECIM:0]    y,
  output logic                                  y_valid,
  input  logic                                  y_ready,
  output logic                                  overrun,
  input  logic                                  clear_overrun,
  output logic [PWM_BITS:0]                     w_out
);
  localparam int W_BITS   = PWM_BITS + 1;
  localparam int ACC_BITS = W_BITS + 2 * MAX_LOG2_DECIM;
  localparam int DCNT_W   = MAX_LOG2_DECIM + 1;

  logic [PWM_BITS-1:0] r_pcnt;
  logic [W_BITS-1:0]   r_hcnt;
  logic [W_BITS-1:0]   r_w_p1;
  logic                r_wvld_p1;
  logic [ACC_BITS-1:0] r_i1, r_i2, r_i2_prev, r_c1_prev;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [ACC_BITS-1:0] r_y_p2;
  logic                r_yvld_p2;
  logic                r_ovr;

  logic [7:0]          w_l2c;
  logic [DCNT_W-1:0]   w_rmask;
  logic                w_end;
  logic [ACC_BITS-1:0] w_wext, w_i1n, w_i2n, w_c1, w_c2;
  logic                w_dump;
  logic                w_ovr_evt;

  // Rescale the comb output so full scale is independent of the chosen R.
  function automatic logic [ACC_BITS-1:0] normalize(input logic [ACC_BITS-1:0] c,
                                                     input logic [7:0] l2c);
    int sh;
    sh = 2 * (MAX_LOG2_DECIM - int'(l2c));
    return c << sh;
  endfunction

  always_comb begin
    w_l2c = ({5'd0, log2_decim} > 8'(MAX_LOG2_DECIM)) ? 8'(MAX_LOG2_DECIM)
                                                       : {5'd0, log2_decim};
    w_rmask   = DCNT_W'((32'd1 << w_l2c) - 32'd1);
    w_end     = (r_pcnt == period_max) && !sync;
    w_wext    = ACC_BITS'(r_w_p1);
    w_i1n     = r_i1 + w_wext;
    w_i2n     = r_i2 + w_i1n;
    w_c1      = w_i2n - r_i2_prev;
    w_c2      = w_c1 - r_c1_prev;
    w_dump    = r_wvld_p1 && !clear && (r_dcnt == w_rmask);
    w_ovr_evt = w_dump && r_yvld_p2 && !y_ready;
  end

  // Stage 0 -> p1: period and high-time measurement
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt    <= '0;
      r_hcnt    <= '0;
      r_w_p1    <= '0;
      r_wvld_p1 <= 1'b0;
    end else begin
      r_wvld_p1 <= w_end;
      if (sync) begin
        r_pcnt <= '0;
        r_hcnt <= '0;
      end else if (w_end) begin
        r_pcnt <= '0;
        r_hcnt <= '0;
        r_w_p1 <= r_hcnt + W_BITS'(pwm_in);
      end else begin
        r_pcnt <= r_pcnt + PWM_BITS'(1);
        r_hcnt <= r_hcnt + W_BITS'(pwm_in);
      end
    end
  end

  // Stage p1: integrators and decimating combs (modular arithmetic wraps safely)
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i2_prev <= '0;
      r_c1_prev <= '0;
      r_dcnt    <= '0;
    end else if (r_wvld_p1) begin
      r_i1   <= w_i1n;
      r_i2   <= w_i2n;
      r_dcnt <= w_dump ? '0 : r_dcnt + DCNT_W'(1);
      if (w_dump) begin
        r_i2_prev <= w_i2n;
        r_c1_prev <= w_c1;
      end
    end
  end

  // Stage p2: output register, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_y_p2    <= '0;
      r_yvld_p2 <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_dump) begin
        r_y_p2    <= normalize(w_c2, w_l2c);
        r_yvld_p2 <= 1'b1;
      end else if (r_yvld_p2 && y_ready) begin
        r_yvld_p2 <= 1'b0;
      end
      if (w_ovr_evt)
        r_ovr <= 1'b1;
      else if (clear_overrun)
        r_ovr <= 1'b0;
    end
  end

  assign y       = r_y_p2;
  assign y_valid = r_yvld_p2;
  assign overrun = r_ovr;
  assign w_out   = r_w_p1;

endmodule

// File: tb/tb_pwm_sinc2_demodulator.sv
// Scoreboard bench for pwm_sinc2_demodulator: expected samples are queued as
// PWM periods are driven and popped on each output handshake.
module tb_pwm_sinc2_demodulator;
  logic        clk;
  logic        reset;
  logic        pwm_in;
  logic        sync;
  logic [6:0]  period_max;
  logic [2:0]  log2_decim;
  logic        clear;
  logic [15:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        overrun;
  logic        clear_overrun;
  logic [7:0]  w_out;

  int          n_checks;
  int          n_fail;
  logic        mon_en;
  logic [31:0] exp_q[$];

  pwm_sinc2_demodulator dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .sync(sync),
    .period_max(period_max), .log2_decim(log2_decim), .clear(clear),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .overrun(overrun),
    .clear_overrun(clear_overrun), .w_out(w_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear(input logic [2:0] l2);
    log2_decim = l2;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Sync, then n full periods with pwm high for the first hi cycles, then idle.
  task automatic run_periods(input int n, input int hi);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c <= int'(period_max); c++) begin
        pwm_in = (c < hi);
        tick();
      end
    end
    pwm_in = 1'b0;
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset && y_valid && y_ready) begin
      if (exp_q.size() == 0)
        check_eq("extra_y", 32'(y_valid), 32'd0);
      else begin
        check_eq("y", 32'(y), exp_q.pop_front());
        check_eq("ovr_stream", 32'(overrun), 32'd0);
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; mon_en = 1'b0;
    reset = 1'b1; pwm_in = 1'b0; sync = 1'b0; clear = 1'b0;
    period_max = 7'd9; log2_decim = 3'd0; y_ready = 1'b1; clear_overrun = 1'b0;
    repeat (3) tick();
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_yvld", 32'(y_valid), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_w", 32'(w_out), 32'd0);
    reset = 1'b0;
    tick();

    // R=1, w=3
    mon_en = 1'b1;
    repeat (4) exp_q.push_back(32'd768);
    run_periods(4, 3);
    check_eq("r1_w", 32'(w_out), 32'd3);
    check_eq("r1_drain", 32'(exp_q.size()), 32'd0);

    // R=2 start-up transient
    pulse_clear(3'd1);
    exp_q.push_back(32'd576);
    exp_q.push_back(32'd768);
    exp_q.push_back(32'd768);
    run_periods(6, 3);
    check_eq("r2_drain", 32'(exp_q.size()), 32'd0);

    // Pulse width extremes, R=16
    period_max = 7'd127;
    pulse_clear(3'd4);
    exp_q.push_back(32'd17408);
    exp_q.push_back(32'd32768);
    run_periods(32, 128);
    check_eq("full_w", 32'(w_out), 32'd128);
    check_eq("full_drain", 32'(exp_q.size()), 32'd0);
    pulse_clear(3'd4);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    run_periods(32, 0);
    check_eq("zero_w", 32'(w_out), 32'd0);
    check_eq("zero_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure
    period_max = 7'd9;
    mon_en = 1'b0;
    y_ready = 1'b0;
    pulse_clear(3'd0);
    run_periods(1, 3);
    check_eq("bp1_y", 32'(y), 32'd768);
    check_eq("bp1_yvld", 32'(y_valid), 32'd1);
    check_eq("bp1_ovr", 32'(overrun), 32'd0);
    run_periods(1, 5);
    check_eq("bp2_y", 32'(y), 32'd1280);
    check_eq("bp2_yvld", 32'(y_valid), 32'd1);
    check_eq("bp2_ovr", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    y_ready = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_eq("bp3_ovr", 32'(overrun), 32'd0);
    check_eq("bp3_yvld", 32'(y_valid), 32'd0);

    // Mid-period sync discards the truncated period
    pulse_clear(3'd0);
    mon_en = 1'b1;
    exp_q.push_back(32'd768);
    run_periods(1, 3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    pwm_in = 1'b1;
    repeat (5) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check_eq("trunc_w", 32'(w_out), 32'd3);
    exp_q.push_back(32'd1792);
    for (int c = 0; c <= 9; c++) begin
      pwm_in = (c < 7);
      tick();
    end
    pwm_in = 1'b0;
    repeat (3) tick();
    check_eq("sync_w", 32'(w_out), 32'd7);
    check_eq("sync_drain", 32'(exp_q.size()), 32'd0);

    // clear mid-stream with R change 2 -> 4
    mon_en = 1'b0;
    y_ready = 1'b0;
    pulse_clear(3'd1);
    run_periods(2, 3);
    check_eq("cl1_y", 32'(y), 32'd576);
    check_eq("cl1_yvld", 32'(y_valid), 32'd1);
    run_periods(2, 3);
    check_eq("cl2_y", 32'(y), 32'd768);
    check_eq("cl2_ovr", 32'(overrun), 32'd1);
    pulse_clear(3'd2);
    check_eq("cl3_yvld", 32'(y_valid), 32'd0);
    check_eq("cl3_ovr", 32'(overrun), 32'd0);
    check_eq("cl3_y", 32'(y), 32'd0);
    y_ready = 1'b1;
    mon_en = 1'b1;
    exp_q.push_back(32'd480);
    exp_q.push_back(32'd768);
    run_periods(8, 3);
    check_eq("r4_drain", 32'(exp_q.size()), 32'd0);

    // One-cycle synchronous reset
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_y", 32'(y), 32'd0);
    check_eq("rst2_yvld", 32'(y_valid), 32'd0);
    check_eq("rst2_ovr", 32'(overrun), 32'd0);
    check_eq("rst2_w", 32'(w_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
